ff_d_addr_bit_scanner: RTL and testbench

- Reader counterpart of the addressed single-bit flag register.
- Snapshots a DATA_LEN-bit flag vector and emits the address of each set bit, lowest first, over a valid/ready stream.
- Optionally drives a bit-clear write (wen/addr/data) back into the flag register as each address is consumed.
- Used for pending-bit walks: interrupt pending, dirty or valid vectors.

---
 rtl/ff_d_addr_bit_scanner.sv | 154 +++++++++++++++
 tb/tb_ff_d_addr_bit_scanner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ff_d_addr_bit_scanner.sv
// Snapshots a flag vector and streams the address of each set bit, lowest first.
// Optional clear-write back-channel enabled by defining FF_D_ADDR_SCAN_CLEAR_EN.
module ff_d_addr_bit_scanner #(
   parameter int ADDR_LEN = 2,
   parameter int DATA_LEN = 2**ADDR_LEN
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [DATA_LEN-1:0] vec_in,
   output logic                busy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ADDR_LEN-1:0] out_addr,
   output logic                out_last,
   output logic                done,
   output logic [ADDR_LEN:0]   hit_cnt,
   output logic                clr_wen,
   output logic [ADDR_LEN-1:0] clr_addr,
   output logic                clr_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [DATA_LEN-1:0] ONES = {DATA_LEN{1'b1}};

   state_t              state_q, state_d;
   logic [DATA_LEN-1:0] snap_q, snap_d;
   logic [ADDR_LEN-1:0] idx_q, idx_d;
   logic                valid_q, valid_d;
   logic [ADDR_LEN-1:0] addr_q, addr_d;
   logic                last_q, last_d;
   logic [ADDR_LEN:0]   hit_q, hit_d;

   logic [DATA_LEN-1:0] rem_s;
   logic [DATA_LEN-1:0] above_s;
   logic                hs_s;

   // Remaining bits at/above idx, and strictly above idx for the out_last lookahead.
   assign rem_s   = snap_q & (ONES << idx_q);
   assign above_s = snap_q & (ONES << ({1'b0, idx_q} + {{ADDR_LEN{1'b0}}, 1'b1}));
   assign hs_s    = valid_q & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         snap_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         last_q  <= 1'b0;
         hit_q   <= '0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         hit_q   <= hit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      last_d  = last_q;
      hit_d   = hit_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               snap_d  = vec_in;
               idx_d   = '0;
               hit_d   = '0;
               state_d = S_SCAN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SCAN: begin
            // Presented address is frozen until accepted; scanning resumes after it.
            if (valid_q) begin
               if (hs_s) begin
                  valid_d = 1'b0;
                  hit_d   = hit_q + {{ADDR_LEN{1'b0}}, 1'b1};
                  if (last_q) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d = idx_q + {{(ADDR_LEN-1){1'b0}}, 1'b1};
                  end
               end else begin
                  valid_d = 1'b1;
               end
            end else if (rem_s == '0) begin
               state_d = S_DONE;
            end else if (snap_q[idx_q]) begin
               valid_d = 1'b1;
               addr_d  = idx_q;
               last_d  = (above_s == '0);
            end else begin
               idx_d = idx_q + {{(ADDR_LEN-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign out_valid = valid_q;
   assign out_addr  = addr_q;
   assign out_last  = last_q;
   assign hit_cnt   = hit_q;
   assign clr_data  = 1'b0;

`ifdef FF_D_ADDR_SCAN_CLEAR_EN
   logic                clr_wen_q;
   logic [ADDR_LEN-1:0] clr_addr_q;

   // One-cycle clear pulse for the address consumed on the previous edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clr_wen_q  <= 1'b0;
         clr_addr_q <= '0;
      end else begin
         clr_wen_q <= hs_s;
         if (hs_s) begin
            clr_addr_q <= addr_q;
         end else begin
            clr_addr_q <= clr_addr_q;
         end
      end
   end

   assign clr_wen  = clr_wen_q;
   assign clr_addr = clr_addr_q;
`else
   assign clr_wen  = 1'b0;
   assign clr_addr = '0;
`endif

endmodule

// File: tb/tb_ff_d_addr_bit_scanner.sv
// Directed bench for ff_d_addr_bit_scanner (ADDR_LEN=2); honours FF_D_ADDR_SCAN_CLEAR_EN.
module tb_ff_d_addr_bit_scanner;

`ifdef FF_D_ADDR_SCAN_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] vec_in;
   logic       busy;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_addr;
   logic       out_last;
   logic       done;
   logic [2:0] hit_cnt;
   logic       clr_wen;
   logic [1:0] clr_addr;
   logic       clr_data;

   int checks = 0;
   int errors = 0;

   ff_d_addr_bit_scanner #(.ADDR_LEN(2), .DATA_LEN(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .vec_in   (vec_in),
      .busy     (busy),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_addr (out_addr),
      .out_last (out_last),
      .done     (done),
      .hit_cnt  (hit_cnt),
      .clr_wen  (clr_wen),
      .clr_addr (clr_addr),
      .clr_data (clr_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Outputs that must agree on every stream step: valid, addr, last.
   task automatic chk_out(input string tag, input logic v, input logic [1:0] a, input logic l);
      chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
      if (v) begin
         chk({tag, ".addr"}, {6'd0, out_addr}, {6'd0, a});
         chk({tag, ".last"}, {7'd0, out_last}, {7'd0, l});
      end
   endtask

   task automatic chk_clr(input string tag, input logic w, input logic [1:0] a);
      chk({tag, ".clr_wen"}, {7'd0, clr_wen}, {7'd0, w & CLR_EN});
      chk({tag, ".clr_data"}, {7'd0, clr_data}, 8'd0);
      if (w & CLR_EN) begin
         chk({tag, ".clr_addr"}, {6'd0, clr_addr}, {6'd0, a});
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; vec_in = 4'b0000; out_ready = 1'b0;
      tick(); tick();
      chk("rst.busy", {7'd0, busy}, 8'd0);
      chk("rst.done", {7'd0, done}, 8'd0);
      chk("rst.hit", {5'd0, hit_cnt}, 8'd0);
      chk("rst.addr", {6'd0, out_addr}, 8'd0);
      chk("rst.last", {7'd0, out_last}, 8'd0);
      chk("rst.clr_addr", {6'd0, clr_addr}, 8'd0);
      chk_out("rst", 1'b0, 2'd0, 1'b0);
      chk_clr("rst", 1'b0, 2'd0);
      rst_n = 1'b1;
      tick();

      // 0101, ready high: addr 0 then addr 2 (last)
      vec_in = 4'b0101; out_ready = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      chk("t1.busy", {7'd0, busy}, 8'd1);
      chk_out("t1.s0", 1'b0, 2'd0, 1'b0);
      tick(); chk_out("t1.a0", 1'b1, 2'd0, 1'b0);
      tick(); chk_out("t1.hs0", 1'b0, 2'd0, 1'b0);
      chk("t1.hit1", {5'd0, hit_cnt}, 8'd1);
      chk_clr("t1.clr0", 1'b1, 2'd0);
      tick(); chk_out("t1.skip", 1'b0, 2'd0, 1'b0);
      chk_clr("t1.clr0off", 1'b0, 2'd0);
      tick(); chk_out("t1.a2", 1'b1, 2'd2, 1'b1);
      tick(); chk_out("t1.hs2", 1'b0, 2'd0, 1'b0);
      chk("t1.done", {7'd0, done}, 8'd1);
      chk("t1.busy_done", {7'd0, busy}, 8'd1);
      chk("t1.hit2", {5'd0, hit_cnt}, 8'd2);
      chk_clr("t1.clr2", 1'b1, 2'd2);
      tick();
      chk("t1.done_off", {7'd0, done}, 8'd0);
      chk("t1.idle", {7'd0, busy}, 8'd0);
      chk("t1.hit_hold", {5'd0, hit_cnt}, 8'd2);

      // Empty vector: SCAN then DONE, no output
      vec_in = 4'b0000; start = 1'b1;
      tick(); start = 1'b0;
      chk("t2.done0", {7'd0, done}, 8'd0);
      chk("t2.hit_clr", {5'd0, hit_cnt}, 8'd0);
      chk_out("t2.s0", 1'b0, 2'd0, 1'b0);
      tick();
      chk("t2.done1", {7'd0, done}, 8'd1);
      chk_out("t2.s1", 1'b0, 2'd0, 1'b0);
      tick();
      chk("t2.done_off", {7'd0, done}, 8'd0);
      chk("t2.idle", {7'd0, busy}, 8'd0);

      // 1000 with back-pressure: held stable for 5 cycles
      vec_in = 4'b1000; out_ready = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk_out("t3.hold", 1'b1, 2'd3, 1'b1);
         if (i < 4) tick();
      end
      out_ready = 1'b1;
      tick();
      chk_out("t3.hs", 1'b0, 2'd0, 1'b0);
      chk("t3.done", {7'd0, done}, 8'd1);
      chk("t3.hit", {5'd0, hit_cnt}, 8'd1);
      chk_clr("t3.clr", 1'b1, 2'd3);
      tick();
      chk("t3.idle", {7'd0, busy}, 8'd0);

      // 0010 with vec change and start re-pulse mid-scan
      vec_in = 4'b0010; start = 1'b1;
      tick(); start = 1'b0; vec_in = 4'b1111;
      tick(); start = 1'b1;
      tick(); start = 1'b0;
      chk_out("t4.a1", 1'b1, 2'd1, 1'b1);
      tick();
      chk("t4.done", {7'd0, done}, 8'd1);
      chk("t4.hit", {5'd0, hit_cnt}, 8'd1);
      tick();
      chk("t4.idle", {7'd0, busy}, 8'd0);
      chk_out("t4.none", 1'b0, 2'd0, 1'b0);
      vec_in = 4'b0000;

      // Reset while addr 2 is presented
      vec_in = 4'b0100; out_ready = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick();
      chk_out("t5.a2", 1'b1, 2'd2, 1'b1);
      rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      chk_out("t5.rst", 1'b0, 2'd0, 1'b0);
      chk("t5.busy", {7'd0, busy}, 8'd0);
      chk("t5.hit", {5'd0, hit_cnt}, 8'd0);
      chk_clr("t5.clr", 1'b0, 2'd0);
      vec_in = 4'b0001; out_ready = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      tick(); chk_out("t5.a0", 1'b1, 2'd0, 1'b1);
      tick();
      chk("t5.done", {7'd0, done}, 8'd1);
      chk("t5.hit1", {5'd0, hit_cnt}, 8'd1);
      tick();

      // 0110: clear pulses at addr 1 then addr 2
      vec_in = 4'b0110; start = 1'b1;
      tick(); start = 1'b0;
      tick();
      tick(); chk_out("t6.a1", 1'b1, 2'd1, 1'b0);
      chk_clr("t6.pre", 1'b0, 2'd0);
      tick(); chk_clr("t6.clr1", 1'b1, 2'd1);
      tick(); chk_out("t6.a2", 1'b1, 2'd2, 1'b1);
      chk_clr("t6.gap", 1'b0, 2'd0);
      tick(); chk_clr("t6.clr2", 1'b1, 2'd2);
      chk("t6.hit", {5'd0, hit_cnt}, 8'd2);
      tick(); chk_clr("t6.end", 1'b0, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
